// File: rtl/display_scan_controller.sv
// Purpose : time-multiplexes one hex 7-segment decoder across NUM_DIGITS common-anode digits with a dark gap before each digit.
// Latency : all outputs registered; a load commits at the next frame boundary, or one cycle after capture while scanning is disabled.
// Backpressure: none; load is a fire-and-forget strobe, and repeated loads before a commit overwrite staging (last write wins).
module display_scan_controller #(
  parameter int NUM_DIGITS   = 4,
  parameter int DIG_CYCLES   = 50000,
  parameter int BLANK_CYCLES = 500,
  parameter int LZ_BLANK     = 1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            en,
  input  logic [4*NUM_DIGITS-1:0]         value,
  input  logic [NUM_DIGITS-1:0]           dp_mask,
  input  logic                            load,
  output logic                            load_pending,
  output logic [NUM_DIGITS-1:0]           anode,
  output logic [3:0]                      num,
  output logic                            dp,
  output logic [$clog2(NUM_DIGITS)-1:0]   digit_idx,
  output logic                            frame_done
);

  localparam int IW   = $clog2(NUM_DIGITS);
  localparam int MAXC = (DIG_CYCLES > BLANK_CYCLES) ? DIG_CYCLES : BLANK_CYCLES;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [CW-1:0] DIG_LAST   = CW'(DIG_CYCLES - 1);
  localparam logic [IW-1:0] LAST_IDX   = IW'(NUM_DIGITS - 1);

  typedef enum logic {BLANK = 1'b0, ACTIVE = 1'b1} state_t;

  state_t                   state, nxt_state;
  logic [CW-1:0]            cnt, nxt_cnt;
  logic [IW-1:0]            nxt_idx;
  logic                     frame_end;
  logic                     commit;
  logic                     nxt_pending;
  logic [4*NUM_DIGITS-1:0]  stage_val, disp_val, nxt_disp_val;
  logic [NUM_DIGITS-1:0]    stage_dpm, disp_dpm, nxt_disp_dpm;
  logic [NUM_DIGITS-1:0]    lz_dark;
  logic [NUM_DIGITS-1:0]    nxt_anode;
  logic [3:0]               sel_num;
  logic                     sel_dp;
  logic                     sel_dark;

  // Scan sequencing: BLANK gap, then ACTIVE digit; the last digit's end closes the frame.
  always_comb begin
    nxt_state = state;
    nxt_cnt   = cnt + 1'b1;
    nxt_idx   = digit_idx;
    frame_end = 1'b0;
    if (!en) begin
      nxt_state = BLANK;
      nxt_cnt   = '0;
    end else if (state == BLANK) begin
      if (cnt == BLANK_LAST) begin
        nxt_state = ACTIVE;
        nxt_cnt   = '0;
      end
    end else if (cnt == DIG_LAST) begin
      nxt_state = BLANK;
      nxt_cnt   = '0;
      if (digit_idx == LAST_IDX) begin
        nxt_idx   = '0;
        frame_end = 1'b1;
      end else begin
        nxt_idx = digit_idx + 1'b1;
      end
    end
  end

  // Commit decision: frame boundary, or immediately while the display is held dark.
  // A load coinciding with a commit bypasses staging so the newest value is shown.
  always_comb begin
    commit       = frame_end | (~en & load_pending);
    nxt_disp_val = disp_val;
    nxt_disp_dpm = disp_dpm;
    nxt_pending  = load_pending;
    if (commit) begin
      nxt_pending = 1'b0;
      if (load) begin
        nxt_disp_val = value;
        nxt_disp_dpm = dp_mask;
      end else begin
        nxt_disp_val = stage_val;
        nxt_disp_dpm = stage_dpm;
      end
    end else if (load) begin
      nxt_pending = 1'b1;
    end
  end

  // Leading-zero mask and per-digit output selection, computed from next-cycle state.
  always_comb begin
    logic zero_run;
    zero_run = 1'b1;
    lz_dark  = '0;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      zero_run   = zero_run & (nxt_disp_val[4*i +: 4] == 4'h0);
      lz_dark[i] = (LZ_BLANK != 0) && zero_run;
    end
    sel_num   = 4'h0;
    sel_dp    = 1'b0;
    sel_dark  = 1'b0;
    nxt_anode = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (nxt_idx == IW'(i)) begin
        sel_num      = nxt_disp_val[4*i +: 4];
        sel_dp       = nxt_disp_dpm[i];
        sel_dark     = lz_dark[i];
        nxt_anode[i] = !((nxt_state == ACTIVE) && !lz_dark[i]);
      end
    end
  end

  // FSM state, cycle counter and digit index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= BLANK;
      cnt       <= '0;
      digit_idx <= '0;
    end else begin
      state     <= nxt_state;
      cnt       <= nxt_cnt;
      digit_idx <= nxt_idx;
    end
  end

  // Double-buffered value: staging captures every load, display updates on commit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_val    <= '0;
      stage_dpm    <= '0;
      disp_val     <= '0;
      disp_dpm     <= '0;
      load_pending <= 1'b0;
    end else begin
      if (load) begin
        stage_val <= value;
        stage_dpm <= dp_mask;
      end
      disp_val     <= nxt_disp_val;
      disp_dpm     <= nxt_disp_dpm;
      load_pending <= nxt_pending;
    end
  end

  // Registered display drive; a blanked digit also keeps its decimal point dark.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      anode      <= '1;
      num        <= 4'h0;
      dp         <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      anode      <= nxt_anode;
      num        <= sel_num;
      dp         <= sel_dark | ~sel_dp;
      frame_done <= frame_end;
    end
  end

endmodule
